// File: rtl/trig_pkg.sv
// Shared types and constants for the wake-up trigger link.
`timescale 1ns/1ps
package trig_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        GAP,
        WAIT_LOW
    } wu_state_t;

    localparam int RESP_TIMEOUT = 14000;
    localparam int COUNT_W      = 20;

    localparam int DEF_PULSE_W  = 100;
    localparam int DEF_GAP_W    = 15000;
    localparam int DEF_ACK_WIN  = 16;

endpackage

// File: rtl/wu_sync.sv
// Two-flop synchronizer for the responder's WU_valid, with rising-edge detect.
`timescale 1ns/1ps
module wu_sync (
    input  logic clki,
    input  logic rst,
    input  logic async_in,
    output logic level,
    output logic rise
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clki) begin
        if (rst) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= async_in;
            sync <= meta;
            prev <= sync;
        end
    end

    assign level = sync;
    assign rise  = sync & ~prev;

endmodule

// File: rtl/wakeup_gen.sv
// Wake-up pulse burst generator: drives timed wake_up pulses and checks each
// one for a WU_valid acknowledge from the responder.
`timescale 1ns/1ps
module wakeup_gen
    import trig_pkg::*;
#(
    parameter int PULSE_W = DEF_PULSE_W,
    parameter int GAP_W   = DEF_GAP_W,
    parameter int ACK_WIN = DEF_ACK_WIN
) (
    input  logic               clki,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [15:0]        burst_len,
    input  logic               wu_valid_in,
    output logic               wake_up,
    output logic               busy,
    output logic [COUNT_W-1:0] sent_count,
    output logic [COUNT_W-1:0] ack_count,
    output logic               miss,
    output logic               done
);

    localparam int TIMER_MAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
    localparam int TIMER_W   = $clog2(TIMER_MAX);
    localparam int WIN_W     = $clog2(ACK_WIN);

    wu_state_t          state;
    wu_state_t          state_next;
    logic [TIMER_W-1:0] timer;
    logic [15:0]        remaining;
    logic [WIN_W-1:0]   win_k;
    logic               win_active;
    logic               sync_level;
    logic               sync_rise;
    logic               pulse_end;
    logic               gap_end;
    logic               last_pulse;
    logic               pulse_entry;
    logic               burst_end;
    logic               ack_event;
    logic               miss_event;

    wu_sync u_sync (
        .clki     (clki),
        .rst      (rst),
        .async_in (wu_valid_in),
        .level    (sync_level),
        .rise     (sync_rise)
    );

    assign pulse_end   = (state == PULSE) && (timer == TIMER_W'(PULSE_W - 1));
    assign gap_end     = (state == GAP) && (timer == TIMER_W'(GAP_W - 1));
    assign last_pulse  = (remaining == 16'd1);
    assign pulse_entry = (state_next == PULSE) && (state != PULSE);
    assign burst_end   = gap_end && last_pulse && !abort;
    assign ack_event   = win_active && sync_rise && !abort;
    assign miss_event  = win_active && !sync_rise && !abort &&
                         (win_k == WIN_W'(ACK_WIN - 1));

    // WAIT_LOW keeps the next rise from landing inside a still-open responder window.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (start) state_next = PULSE;
            PULSE:    if (pulse_end) state_next = GAP;
            GAP: begin
                if (gap_end) begin
                    if (last_pulse)      state_next = IDLE;
                    else if (sync_level) state_next = WAIT_LOW;
                    else                 state_next = PULSE;
                end
            end
            WAIT_LOW: if (!sync_level) state_next = PULSE;
            default:  state_next = IDLE;
        endcase
        if (abort) state_next = IDLE;
    end

    always_ff @(posedge clki) begin
        if (rst) begin
            state     <= IDLE;
            timer     <= '0;
            remaining <= '0;
        end else begin
            state <= state_next;
            if (state_next != state)
                timer <= '0;
            else if (state == PULSE || state == GAP)
                timer <= timer + 1'b1;
            // remaining == 0 marks a continuous burst and is never decremented
            if (state == IDLE && state_next == PULSE)
                remaining <= burst_len;
            else if (gap_end && state_next != IDLE && remaining != 16'd0)
                remaining <= remaining - 16'd1;
        end
    end

    always_ff @(posedge clki) begin
        if (rst) begin
            wake_up <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            miss    <= 1'b0;
        end else begin
            wake_up <= (state_next == PULSE);
            busy    <= (state_next != IDLE);
            done    <= burst_end;
            miss    <= miss_event;
        end
    end

    always_ff @(posedge clki) begin
        if (rst)
            sent_count <= '0;
        else if (pulse_entry)
            sent_count <= sent_count + 1'b1;
    end

    always_ff @(posedge clki) begin
        if (rst)
            ack_count <= '0;
        else if (ack_event)
            ack_count <= ack_count + 1'b1;
    end

    // Window index k equals win_k while win_active; closes on first ack or at miss.
    always_ff @(posedge clki) begin
        if (rst) begin
            win_active <= 1'b0;
            win_k      <= '0;
        end else if (pulse_entry) begin
            win_active <= 1'b1;
            win_k      <= '0;
        end else if (abort || ack_event || miss_event) begin
            win_active <= 1'b0;
        end else if (win_active) begin
            win_k <= win_k + 1'b1;
        end
    end

endmodule

// File: tb/tb_wakeup_gen.sv
// Directed self-checking bench for wakeup_gen with a simple responder model.
`timescale 1ns/1ps
module tb_wakeup_gen;

    logic        clki;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] burst_len;
    logic        wu_valid_in;
    logic        wake_up;
    logic        busy;
    logic [19:0] sent_count;
    logic [19:0] ack_count;
    logic        miss;
    logic        done;

    int total = 0;
    int bad   = 0;

    // responder model: WU_valid high from k=3 for resp_hold cycles after each rise
    logic resp_en   = 1'b0;
    int   resp_hold = 14000;
    int   resp_k    = -1;
    logic wu_prev_r = 1'b0;

    wakeup_gen dut (
        .clki        (clki),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .burst_len   (burst_len),
        .wu_valid_in (wu_valid_in),
        .wake_up     (wake_up),
        .busy        (busy),
        .sent_count  (sent_count),
        .ack_count   (ack_count),
        .miss        (miss),
        .done        (done)
    );

    initial clki = 1'b0;
    always #5 clki = ~clki;

    always @(posedge clki) begin
        if (wake_up && !wu_prev_r)
            resp_k <= 0;
        else if (resp_k >= 0)
            resp_k <= resp_k + 1;
        wu_prev_r <= wake_up;
    end

    always_comb wu_valid_in = resp_en && (resp_k >= 2) && (resp_k < 2 + resp_hold);

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; burst_len = 16'd0;
        repeat (3) @(negedge clki);
        rst = 1'b0;
    endtask

    // returns at the negedge of cycle k=0 of the first pulse
    task automatic launch(input logic [15:0] n);
        @(negedge clki);
        start = 1'b1; burst_len = n;
        @(negedge clki);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; burst_len = 16'd0;
        repeat (2) @(negedge clki);
        total++; if (wake_up !== 1'b0) begin bad++; $display("[TB] FAIL rst_wake_up got=%b exp=0", wake_up); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_busy got=%b exp=0", busy); end
        total++; if (miss !== 1'b0) begin bad++; $display("[TB] FAIL rst_miss got=%b exp=0", miss); end
        total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL rst_done got=%b exp=0", done); end
        total++; if (sent_count !== 20'd0) begin bad++; $display("[TB] FAIL rst_sent got=%0d exp=0", sent_count); end
        total++; if (ack_count !== 20'd0) begin bad++; $display("[TB] FAIL rst_ack got=%0d exp=0", ack_count); end
        rst = 1'b0;
    endtask

    task automatic test_burst_ack();
        int   rises = 1, last_rise = 0, high_len = 1;
        int   bad_width = 0, bad_gap = 0, misses = 0, dones = 0, done_n = -1;
        logic done_busy = 1'b1, prev;
        do_reset();
        resp_en = 1'b1; resp_hold = 14000;
        launch(16'd3);
        total++; if (wake_up !== 1'b1 || busy !== 1'b1) begin bad++; $display("[TB] FAIL t1_first_rise got=%b%b exp=11", wake_up, busy); end
        for (int n = 1; n < 46000 && done_n < 0; n++) begin
            prev = wake_up;
            @(negedge clki);
            if (wake_up && !prev) begin
                rises++;
                if (n - last_rise != 15100) bad_gap++;
                last_rise = n; high_len = 1;
            end else if (wake_up) high_len++;
            else if (prev && high_len != 100) bad_width++;
            if (miss) misses++;
            if (done) begin dones++; done_busy = busy; done_n = n; end
        end
        repeat (5) begin @(negedge clki); if (done) dones++; end
        total++; if (done_n !== 45300) begin bad++; $display("[TB] FAIL t1_done_cycle got=%0d exp=45300", done_n); end
        total++; if (rises !== 3) begin bad++; $display("[TB] FAIL t1_rises got=%0d exp=3", rises); end
        total++; if (bad_width !== 0) begin bad++; $display("[TB] FAIL t1_width_errors got=%0d exp=0", bad_width); end
        total++; if (bad_gap !== 0) begin bad++; $display("[TB] FAIL t1_spacing_errors got=%0d exp=0", bad_gap); end
        total++; if (misses !== 0) begin bad++; $display("[TB] FAIL t1_misses got=%0d exp=0", misses); end
        total++; if (dones !== 1) begin bad++; $display("[TB] FAIL t1_done_count got=%0d exp=1", dones); end
        total++; if (done_busy !== 1'b0) begin bad++; $display("[TB] FAIL t1_busy_at_done got=%b exp=0", done_busy); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL t1_busy_after got=%b exp=0", busy); end
        total++; if (sent_count !== 20'd3) begin bad++; $display("[TB] FAIL t1_sent got=%0d exp=3", sent_count); end
        total++; if (ack_count !== 20'd3) begin bad++; $display("[TB] FAIL t1_ack got=%0d exp=3", ack_count); end
    endtask

    // no responder; a start issued mid-burst must not reload remaining
    task automatic test_no_ack();
        int   last_rise = 0, nmiss = 0, miss_k0 = -1, miss_k1 = -1, gap1 = -1, dones = 0;
        logic prev;
        do_reset();
        resp_en = 1'b0;
        launch(16'd2);
        for (int n = 1; n < 15300 && nmiss < 2; n++) begin
            prev = wake_up;
            @(negedge clki);
            if (n == 30) begin start = 1'b1; burst_len = 16'd1; end
            else if (n == 31) start = 1'b0;
            if (wake_up && !prev) begin gap1 = n - last_rise; last_rise = n; end
            if (done) dones++;
            if (miss) begin
                if (nmiss == 0) miss_k0 = n - last_rise; else miss_k1 = n - last_rise;
                nmiss++;
            end
        end
        total++; if (nmiss !== 2) begin bad++; $display("[TB] FAIL t2_miss_count got=%0d exp=2", nmiss); end
        total++; if (miss_k0 !== 16) begin bad++; $display("[TB] FAIL t2_miss0_k got=%0d exp=16", miss_k0); end
        total++; if (miss_k1 !== 16) begin bad++; $display("[TB] FAIL t2_miss1_k got=%0d exp=16", miss_k1); end
        total++; if (gap1 !== 15100) begin bad++; $display("[TB] FAIL t2_second_rise got=%0d exp=15100", gap1); end
        total++; if (dones !== 0) begin bad++; $display("[TB] FAIL t2_done got=%0d exp=0", dones); end
        total++; if (ack_count !== 20'd0) begin bad++; $display("[TB] FAIL t2_ack got=%0d exp=0", ack_count); end
        total++; if (sent_count !== 20'd2) begin bad++; $display("[TB] FAIL t2_sent got=%0d exp=2", sent_count); end
        abort = 1'b1;
        @(negedge clki);
        abort = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL t2_abort_busy got=%b exp=0", busy); end
    endtask

    task automatic test_wait_low();
        int   rise_n = -1;
        logic wu_at_gap_end = 1'b1, busy_at_gap_end = 1'b0, prev;
        do_reset();
        resp_en = 1'b1; resp_hold = 20000;
        launch(16'd2);
        for (int n = 1; n < 21000 && rise_n < 0; n++) begin
            prev = wake_up;
            @(negedge clki);
            if (n == 15100) begin wu_at_gap_end = wake_up; busy_at_gap_end = busy; end
            if (wake_up && !prev) rise_n = n;
        end
        total++; if (wu_at_gap_end !== 1'b0) begin bad++; $display("[TB] FAIL t3_held_low got=%b exp=0", wu_at_gap_end); end
        total++; if (busy_at_gap_end !== 1'b1) begin bad++; $display("[TB] FAIL t3_busy_wait got=%b exp=1", busy_at_gap_end); end
        total++; if (rise_n !== 20006) begin bad++; $display("[TB] FAIL t3_next_rise got=%0d exp=20006", rise_n); end
        total++; if (ack_count !== 20'd1) begin bad++; $display("[TB] FAIL t3_ack got=%0d exp=1", ack_count); end
        total++; if (sent_count !== 20'd2) begin bad++; $display("[TB] FAIL t3_sent got=%0d exp=2", sent_count); end
        abort = 1'b1;
        @(negedge clki);
        abort = 1'b0;
        resp_en = 1'b0;
    endtask

    task automatic test_abort_pulse();
        int misses = 0, dones = 0;
        do_reset();
        resp_en = 1'b0;
        launch(16'd0);
        repeat (8) @(negedge clki);
        abort = 1'b1;
        @(negedge clki);
        abort = 1'b0;
        total++; if (wake_up !== 1'b0) begin bad++; $display("[TB] FAIL t4_wake_up got=%b exp=0", wake_up); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL t4_busy got=%b exp=0", busy); end
        repeat (30) begin
            if (miss) misses++;
            if (done) dones++;
            @(negedge clki);
        end
        total++; if (misses !== 0) begin bad++; $display("[TB] FAIL t4_miss got=%0d exp=0", misses); end
        total++; if (dones !== 0) begin bad++; $display("[TB] FAIL t4_done got=%0d exp=0", dones); end
        total++; if (sent_count !== 20'd1) begin bad++; $display("[TB] FAIL t4_sent got=%0d exp=1", sent_count); end
    endtask

    task automatic test_start_abort_idle();
        do_reset();
        @(negedge clki);
        start = 1'b1; abort = 1'b1; burst_len = 16'd3;
        @(negedge clki);
        start = 1'b0; abort = 1'b0;
        total++; if (wake_up !== 1'b0 || busy !== 1'b0) begin bad++; $display("[TB] FAIL t5_idle got=%b%b exp=00", wake_up, busy); end
        repeat (5) @(negedge clki);
        total++; if (sent_count !== 20'd0) begin bad++; $display("[TB] FAIL t5_sent got=%0d exp=0", sent_count); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL t5_busy_later got=%b exp=0", busy); end
    endtask

    task automatic test_wrap_and_reset();
        do_reset();
        resp_en = 1'b1; resp_hold = 14000;
        @(negedge clki);
        force dut.sent_count = 20'hFFFFF;
        @(negedge clki);
        release dut.sent_count;
        launch(16'd1);
        total++; if (sent_count !== 20'd0) begin bad++; $display("[TB] FAIL t6_wrap got=%0h exp=0", sent_count); end
        repeat (150) @(negedge clki);
        total++; if (wake_up !== 1'b0 || busy !== 1'b1) begin bad++; $display("[TB] FAIL t6_in_gap got=%b%b exp=01", wake_up, busy); end
        total++; if (ack_count !== 20'd1) begin bad++; $display("[TB] FAIL t6_ack got=%0d exp=1", ack_count); end
        rst = 1'b1;
        @(negedge clki);
        total++; if (wake_up !== 1'b0) begin bad++; $display("[TB] FAIL t6_rst_wake_up got=%b exp=0", wake_up); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL t6_rst_busy got=%b exp=0", busy); end
        total++; if (miss !== 1'b0 || done !== 1'b0) begin bad++; $display("[TB] FAIL t6_rst_flags got=%b%b exp=00", miss, done); end
        total++; if (ack_count !== 20'd0) begin bad++; $display("[TB] FAIL t6_rst_ack got=%0d exp=0", ack_count); end
        total++; if (sent_count !== 20'd0) begin bad++; $display("[TB] FAIL t6_rst_sent got=%0d exp=0", sent_count); end
        rst = 1'b0;
        repeat (5) @(negedge clki);
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL t6_after_rst_busy got=%b exp=0", busy); end
    endtask

    initial begin
        test_reset();
        test_burst_ack();
        test_no_ack();
        test_wait_low();
        test_abort_pulse();
        test_start_abort_idle();
        test_wrap_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
